mem_controller: RTL

Byte-serial memory controller between the instruction cache, the load/store buffer and the single-port 8-bit RAM/IO bus. It accepts word fetches from `iCache` and byte/half/word loads and stores from the LSB. It serialises each request into per-byte RAM cycles, assembles little-endian results and returns them with a one-cycle valid pulse. Only one transaction is in flight at a time.

---
 rtl/mem_controller.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_controller.sv
// Byte-serial memory controller: serialises iCache word fetches and LSB loads/stores onto an 8-bit RAM bus.
// Optional build macro IO_BUFFER_FULL_CHECK_EN adds io_buffer_full back-pressure on I/O-space writes.
module mem_controller #(
    parameter logic [31:0] IO_BOUNDARY = 32'h30000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] iCache2memCon_address,
    input  logic        iCache2memCon_enable,
    output logic [31:0] memCon2iCache_return,
    output logic        memCon2iCache_valid,
    input  logic        lsb2memCon_enable,
    input  logic        lsb2memCon_wr,
    input  logic [31:0] lsb2memCon_address,
    input  logic [1:0]  lsb2memCon_size,
    input  logic [31:0] lsb2memCon_data,
    output logic [31:0] memCon2lsb_return,
    output logic        memCon2lsb_valid,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr
`ifdef IO_BUFFER_FULL_CHECK_EN
    ,
    input  logic        io_buffer_full
`endif
);

    // state | meaning
    // IDLE  | waiting for a request; LSB wins over iCache
    // READ  | issuing addresses and capturing bytes one cycle behind
    // WRITE | driving one byte per cycle with mem_wr
    // DONE  | valid pulse to the requester; enables ignored
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t      state;
    logic        req_lsb;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [1:0]  n_last;
    logic [2:0]  cnt;
    logic [31:0] rbuf;
    logic [31:0] mem_a_q;
    logic [7:0]  dout_q;
    logic        wr_q;
    logic [31:0] ic_ret;
    logic        ic_valid;
    logic [31:0] lsb_ret;
    logic        lsb_valid;
    logic        rdy_q;
    logic [7:0]  din_skid;

    logic [7:0]  din_now;
    logic [31:0] rbuf_next;
    logic [2:0]  cnt_last;
    logic [1:0]  wr_idx_next;
    logic [7:0]  wr_byte_next;
    logic        io_hold;
    logic        io_gap;

    function automatic logic [1:0] size_to_last(input logic [1:0] size);
        case (size)
            2'd0:    return 2'd0;
            2'd1:    return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    // During a stall the RAM keeps answering for the held address, so the
    // byte that was in flight when the stall began is parked here.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rdy_q    <= 1'b0;
            din_skid <= 8'h00;
        end else begin
            rdy_q <= rdy_in;
            if (!rdy_in && rdy_q)
                din_skid <= mem_din;
        end
    end

    assign din_now  = rdy_q ? mem_din : din_skid;
    assign cnt_last = {1'b0, n_last};

    always_comb begin
        rbuf_next = rbuf;
        case (cnt)
            3'd1:    rbuf_next[7:0]   = din_now;
            3'd2:    rbuf_next[15:8]  = din_now;
            3'd3:    rbuf_next[23:16] = din_now;
            3'd4:    rbuf_next[31:24] = din_now;
            default: rbuf_next = rbuf;
        endcase
    end

    assign wr_idx_next = cnt[1:0] + 2'd1;

    always_comb begin
        case (wr_idx_next)
            2'd0:    wr_byte_next = data_q[7:0];
            2'd1:    wr_byte_next = data_q[15:8];
            2'd2:    wr_byte_next = data_q[23:16];
            default: wr_byte_next = data_q[31:24];
        endcase
    end

`ifdef IO_BUFFER_FULL_CHECK_EN
    logic is_io;
    assign is_io   = (mem_a_q >= IO_BOUNDARY);
    assign io_hold = wr_q & is_io & io_buffer_full;
    assign io_gap  = wr_q & is_io;
`else
    assign io_hold = 1'b0;
    assign io_gap  = 1'b0;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state     <= IDLE;
            req_lsb   <= 1'b0;
            addr_q    <= 32'h0;
            data_q    <= 32'h0;
            n_last    <= 2'd0;
            cnt       <= 3'd0;
            rbuf      <= 32'h0;
            mem_a_q   <= 32'h0;
            dout_q    <= 8'h00;
            wr_q      <= 1'b0;
            ic_ret    <= 32'h0;
            ic_valid  <= 1'b0;
            lsb_ret   <= 32'h0;
            lsb_valid <= 1'b0;
        end else if (rdy_in) begin
            ic_valid  <= 1'b0;
            lsb_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (lsb2memCon_enable) begin
                        req_lsb <= 1'b1;
                        addr_q  <= lsb2memCon_address;
                        data_q  <= lsb2memCon_data;
                        n_last  <= size_to_last(lsb2memCon_size);
                        cnt     <= 3'd0;
                        rbuf    <= 32'h0;
                        mem_a_q <= lsb2memCon_address;
                        if (lsb2memCon_wr) begin
                            state  <= WRITE;
                            wr_q   <= 1'b1;
                            dout_q <= lsb2memCon_data[7:0];
                        end else begin
                            state <= READ;
                        end
                    end else if (iCache2memCon_enable) begin
                        req_lsb <= 1'b0;
                        addr_q  <= iCache2memCon_address;
                        n_last  <= 2'd3;
                        cnt     <= 3'd0;
                        rbuf    <= 32'h0;
                        mem_a_q <= iCache2memCon_address;
                        state   <= READ;
                    end
                end
                READ: begin
                    rbuf <= rbuf_next;
                    cnt  <= cnt + 3'd1;
                    if (cnt < cnt_last)
                        mem_a_q <= addr_q + {29'd0, cnt} + 32'd1;
                    if (cnt == cnt_last + 3'd1) begin
                        state <= DONE;
                        if (req_lsb) begin
                            lsb_ret   <= rbuf_next;
                            lsb_valid <= 1'b1;
                        end else begin
                            ic_ret   <= rbuf_next;
                            ic_valid <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    // An I/O byte is followed by one quiet cycle before moving on.
                    if (!io_hold) begin
                        if (io_gap) begin
                            wr_q   <= 1'b0;
                            dout_q <= 8'h00;
                        end else if (cnt[1:0] == n_last) begin
                            wr_q      <= 1'b0;
                            dout_q    <= 8'h00;
                            state     <= DONE;
                            lsb_valid <= 1'b1;
                        end else begin
                            cnt     <= cnt + 3'd1;
                            mem_a_q <= addr_q + {29'd0, cnt} + 32'd1;
                            dout_q  <= wr_byte_next;
                            wr_q    <= 1'b1;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_wr               = wr_q & rdy_in & ~io_hold;
    assign mem_dout             = mem_wr ? dout_q : 8'h00;
    assign mem_a                = mem_a_q;
    assign memCon2iCache_return = ic_ret;
    assign memCon2iCache_valid  = ic_valid;
    assign memCon2lsb_return    = lsb_ret;
    assign memCon2lsb_valid     = lsb_valid;

endmodule
